// File: rtl/vga_scanout_pkg.sv
// vga_scanout_pkg
//   Shared definitions for the VGA scanout block and anything that talks to
//   it (top level, bench).
//   - Default 640x480@60 timing constants and their line/frame totals.
//   - vga_ctrl_t: the per-pixel control flags that travel down the output
//     pipeline alongside the frame buffer read.
//   - Small constant helper functions used to size counters.
package vga_scanout_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int line_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Width of a counter that must hold 0..n-1; never narrower than 1 bit.
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_H_TOTAL = line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Sync flags are carried active-high; pin polarity is applied at the output.
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic vblank_start;
  } vga_ctrl_t;

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Free-running horizontal/vertical raster counters and the region decode
//   evaluated at counter time (no pipeline delay).
// Ports:
//   clk, rst      pixel clock, synchronous active-high reset
//   h_cnt, v_cnt  raster position, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   line_end      h_cnt is on the last clock of a line
//   frame_end     last clock of the frame (line_end on the last line)
//   ctrl          de / hsync / vsync / vblank_start for the current position
module vga_timing_gen
  import vga_scanout_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int H_CNT_W  = bits_for(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int V_CNT_W  = bits_for(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic               clk,
  input  logic               rst,
  output logic [H_CNT_W-1:0] h_cnt,
  output logic [V_CNT_W-1:0] v_cnt,
  output logic               line_end,
  output logic               frame_end,
  output vga_ctrl_t          ctrl
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [H_CNT_W-1:0] H_LAST   = H_CNT_W'(H_TOTAL - 1);
  localparam logic [H_CNT_W-1:0] H_ACT    = H_CNT_W'(H_ACTIVE);
  localparam logic [H_CNT_W-1:0] HS_START = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] HS_END   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(V_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_ACT    = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] VS_START = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] VS_END   = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= frame_end ? '0 : v_cnt + V_CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + H_CNT_W'(1);
    end
  end

  always_comb begin
    ctrl              = '0;
    ctrl.de           = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    ctrl.hsync        = (h_cnt >= HS_START) && (h_cnt < HS_END);
    ctrl.vsync        = (v_cnt >= VS_START) && (v_cnt < VS_END);
    ctrl.vblank_start = (h_cnt == '0) && (v_cnt == V_ACT);
  end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout
//   Display-side reader of the frame buffer. Generates VGA timing, issues a
//   read address every clock, upscales the low-resolution frame by pixel and
//   line replication and drives the pins. H_ACTIVE must be an integer
//   multiple of HORIZ_RESOLUTION, V_ACTIVE of VERT_RESOLUTION, and
//   COLOR_DEPTH a multiple of 3 (R in the MSBs, then G, then B).
// Ports:
//   i_vga_clk, i_rst          pixel clock, synchronous active-high reset
//   i_vga_read_pixel_data     frame buffer data, RAM_LATENCY clocks after address
//   o_vga_horiz_read_addr     frame buffer column address (counter time)
//   o_vga_vert_read_addr      frame buffer row address (counter time)
//   o_vga_hsync, o_vga_vsync  sync pins, polarity set by SYNC_ACTIVE_LOW
//   o_vga_de                  active video
//   o_vga_red/green/blue      colour, forced to 0 outside active video
//   o_vblank_start            one-clock pulse on the first output clock of
//                             the first blank line
//   All pin outputs lag counter time by RAM_LATENCY+1 clocks.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int HORIZ_RESOLUTION = 80,
  parameter int VERT_RESOLUTION  = 60,
  parameter int COLOR_DEPTH      = 12,
  parameter int H_ACTIVE         = DEF_H_ACTIVE,
  parameter int H_FP             = DEF_H_FP,
  parameter int H_SYNC           = DEF_H_SYNC,
  parameter int H_BP             = DEF_H_BP,
  parameter int V_ACTIVE         = DEF_V_ACTIVE,
  parameter int V_FP             = DEF_V_FP,
  parameter int V_SYNC           = DEF_V_SYNC,
  parameter int V_BP             = DEF_V_BP,
  parameter int SYNC_ACTIVE_LOW  = 1,
  parameter int RAM_LATENCY      = 1
) (
  input  logic                                 i_vga_clk,
  input  logic                                 i_rst,
  input  logic [COLOR_DEPTH-1:0]               i_vga_read_pixel_data,
  output logic [$clog2(HORIZ_RESOLUTION)-1:0]  o_vga_horiz_read_addr,
  output logic [$clog2(VERT_RESOLUTION)-1:0]   o_vga_vert_read_addr,
  output logic                                 o_vga_hsync,
  output logic                                 o_vga_vsync,
  output logic                                 o_vga_de,
  output logic [COLOR_DEPTH/3-1:0]             o_vga_red,
  output logic [COLOR_DEPTH/3-1:0]             o_vga_green,
  output logic [COLOR_DEPTH/3-1:0]             o_vga_blue,
  output logic                                 o_vblank_start
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_CNT_W = bits_for(H_TOTAL);
  localparam int V_CNT_W = bits_for(V_TOTAL);
  localparam int HSCALE  = H_ACTIVE / HORIZ_RESOLUTION;
  localparam int VSCALE  = V_ACTIVE / VERT_RESOLUTION;
  localparam int HSUB_W  = bits_for(HSCALE);
  localparam int VSUB_W  = bits_for(VSCALE);
  localparam int COL_W   = $clog2(HORIZ_RESOLUTION);
  localparam int ROW_W   = $clog2(VERT_RESOLUTION);
  localparam int CH_W    = COLOR_DEPTH / 3;
  localparam int STAGES  = RAM_LATENCY + 1;

  localparam logic [HSUB_W-1:0]  HSUB_LAST  = HSUB_W'(HSCALE - 1);
  localparam logic [VSUB_W-1:0]  VSUB_LAST  = VSUB_W'(VSCALE - 1);
  localparam logic [H_CNT_W-1:0] H_ACT_LAST = H_CNT_W'(H_ACTIVE - 1);
  localparam logic [V_CNT_W-1:0] V_ACT_LAST = V_CNT_W'(V_ACTIVE - 1);
  localparam logic               SYNC_INV   = (SYNC_ACTIVE_LOW != 0);

  logic [H_CNT_W-1:0]     h_cnt;
  logic [V_CNT_W-1:0]     v_cnt;
  logic                   line_end;
  logic                   frame_end;
  vga_ctrl_t              ctrl;

  logic [HSUB_W-1:0]      hsub;
  logic [VSUB_W-1:0]      vsub;
  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;

  vga_ctrl_t              ctrl_p [STAGES];
  logic [COLOR_DEPTH-1:0] rgb_p;
  logic [COLOR_DEPTH-1:0] rgb_gated;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .H_CNT_W  (H_CNT_W),
    .V_CNT_W  (V_CNT_W)
  ) u_timing (
    .clk       (i_vga_clk),
    .rst       (i_rst),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .line_end  (line_end),
    .frame_end (frame_end),
    .ctrl      (ctrl)
  );

  // Replication counters are updated from the *current* counter value so the
  // registered address always matches the position the counters move to.
  always_ff @(posedge i_vga_clk) begin
    if (i_rst) begin
      hsub <= '0;
      col  <= '0;
      vsub <= '0;
      row  <= '0;
    end else begin
      // Next pixel still active: step; otherwise (last active pixel, blank or
      // line wrap) the next position is blank or column 0 -> clear.
      if (h_cnt < H_ACT_LAST) begin
        if (hsub == HSUB_LAST) begin
          hsub <= '0;
          col  <= col + COL_W'(1);
        end else begin
          hsub <= hsub + HSUB_W'(1);
        end
      end else begin
        hsub <= '0;
        col  <= '0;
      end

      // Rows advance only between active lines; the last row is held
      // through vertical blank and cleared when the frame wraps.
      if (line_end) begin
        if (frame_end) begin
          vsub <= '0;
          row  <= '0;
        end else if (v_cnt < V_ACT_LAST) begin
          if (vsub == VSUB_LAST) begin
            vsub <= '0;
            row  <= row + ROW_W'(1);
          end else begin
            vsub <= vsub + VSUB_W'(1);
          end
        end
      end
    end
  end

  assign o_vga_horiz_read_addr = col;
  assign o_vga_vert_read_addr  = row;

  // ---- stage p0..p[STAGES-1]: control delay matching RAM latency + RGB register
  always_ff @(posedge i_vga_clk) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) begin
        ctrl_p[i] <= '0;
      end
      rgb_p <= '0;
    end else begin
      ctrl_p[0] <= ctrl;
      for (int i = 1; i < STAGES; i++) begin
        ctrl_p[i] <= ctrl_p[i-1];
      end
      rgb_p <= i_vga_read_pixel_data;
    end
  end

  // ---- output: blanking and sync polarity
  assign rgb_gated      = ctrl_p[STAGES-1].de ? rgb_p : '0;
  assign o_vga_de       = ctrl_p[STAGES-1].de;
  assign o_vga_hsync    = ctrl_p[STAGES-1].hsync ^ SYNC_INV;
  assign o_vga_vsync    = ctrl_p[STAGES-1].vsync ^ SYNC_INV;
  assign o_vblank_start = ctrl_p[STAGES-1].vblank_start;
  assign o_vga_red      = rgb_gated[COLOR_DEPTH-1 -: CH_W];
  assign o_vga_green    = rgb_gated[2*CH_W-1 -: CH_W];
  assign o_vga_blue     = rgb_gated[CH_W-1:0];

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout. Two instances share one clock:
//   dut_d : default 640x480 timing, checked against a table of hand-derived
//           vectors over the first lines (hsync position, address sweep,
//           data alignment with a {row,col} RAM image).
//   dut_s : reduced timing (100x72 raster, 80x64 active, 10x8 buffer, x8
//           replication) so whole frames fit in a short run; every clock is
//           compared with a raster-arithmetic reference model fed from a
//           randomly filled RAM image, plus sync/vblank measurements and a
//           randomly placed mid-frame reset.
module tb_vga_scanout;
  import vga_scanout_pkg::*;

  localparam int S_HR  = 10, S_VR  = 8;
  localparam int S_HA  = 80, S_HFP = 4, S_HS = 8, S_HBP = 8;
  localparam int S_VA  = 64, S_VFP = 2, S_VS = 2, S_VBP = 4;
  localparam int S_HT  = S_HA + S_HFP + S_HS + S_HBP;   // 100
  localparam int S_VT  = S_VA + S_VFP + S_VS + S_VBP;   // 72
  localparam int S_FRAME = S_HT * S_VT;                  // 7200
  localparam int S_HSC = S_HA / S_HR, S_VSC = S_VA / S_VR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance signals
  logic        rst_d;
  logic [11:0] ram_d;
  logic [6:0]  col_d;
  logic [5:0]  row_d;
  logic        hs_d, vs_d, de_d, vb_d;
  logic [3:0]  r_d, g_d, b_d;

  // reduced instance signals
  logic        rst_s;
  logic [11:0] ram_s;
  logic [3:0]  col_s;
  logic [2:0]  row_s;
  logic        hs_s, vs_s, de_s, vb_s;
  logic [3:0]  r_s, g_s, b_s;

  vga_scanout dut_d (
    .i_vga_clk             (clk),
    .i_rst                 (rst_d),
    .i_vga_read_pixel_data (ram_d),
    .o_vga_horiz_read_addr (col_d),
    .o_vga_vert_read_addr  (row_d),
    .o_vga_hsync           (hs_d),
    .o_vga_vsync           (vs_d),
    .o_vga_de              (de_d),
    .o_vga_red             (r_d),
    .o_vga_green           (g_d),
    .o_vga_blue            (b_d),
    .o_vblank_start        (vb_d)
  );

  vga_scanout #(
    .HORIZ_RESOLUTION (S_HR),
    .VERT_RESOLUTION  (S_VR),
    .COLOR_DEPTH      (12),
    .H_ACTIVE         (S_HA),
    .H_FP             (S_HFP),
    .H_SYNC           (S_HS),
    .H_BP             (S_HBP),
    .V_ACTIVE         (S_VA),
    .V_FP             (S_VFP),
    .V_SYNC           (S_VS),
    .V_BP             (S_VBP),
    .SYNC_ACTIVE_LOW  (1),
    .RAM_LATENCY      (1)
  ) dut_s (
    .i_vga_clk             (clk),
    .i_rst                 (rst_s),
    .i_vga_read_pixel_data (ram_s),
    .o_vga_horiz_read_addr (col_s),
    .o_vga_vert_read_addr  (row_s),
    .o_vga_hsync           (hs_s),
    .o_vga_vsync           (vs_s),
    .o_vga_de              (de_s),
    .o_vga_red             (r_s),
    .o_vga_green           (g_s),
    .o_vga_blue            (b_s),
    .o_vblank_start        (vb_s)
  );

  // RAM models, one clock read latency
  logic [11:0] mem_s [0:7][0:15];
  logic        force_s;
  always @(posedge clk) ram_d <= {row_d, col_d[5:0]};
  always @(posedge clk) ram_s <= force_s ? 12'hFFF : mem_s[row_s][col_s];

  int checks = 0, passed = 0;
  int k_d, k_s;                 // clocks since reset release (0 = reset edge)
  logic chk_en;
  int blk_n, blk_bad;
  string blk_msg;
  int hs_fall, hs_rise, vs_fall, vs_rise;
  logic prev_hs, prev_vs;
  int vb_q[$];
  int blank_bad, lit_bad, de_cnt;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  // Reference: output at k is the raster position k-2 (address latency 1 +
  // output register); before that the reset values are still visible.
  function automatic logic [15:0] model_s(input int k);
    int c, h, v;
    logic de, hs, vs, vb;
    logic [11:0] px;
    if (k < 2) return {1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
    c  = k - 2;
    h  = c % S_HT;
    v  = (c / S_HT) % S_VT;
    de = (h < S_HA) && (v < S_VA);
    hs = !((h >= S_HA + S_HFP) && (h < S_HA + S_HFP + S_HS));
    vs = !((v >= S_VA + S_VFP) && (v < S_VA + S_VFP + S_VS));
    vb = (h == 0) && (v == S_VA);
    if (!de)          px = 12'h000;
    else if (force_s) px = 12'hFFF;
    else              px = mem_s[v / S_VSC][h / S_HSC];
    return {hs, vs, de, vb, px};
  endfunction

  task automatic flush_s();
    if (blk_n > 0) begin
      checks++;
      if (blk_bad == 0) passed++;
      else $display("FAIL scan_block: %0d bad cycles, first %s", blk_bad, blk_msg);
      blk_n   = 0;
      blk_bad = 0;
    end
  endtask

  task automatic check_small();
    logic [15:0] got, want;
    int h, v, e_col;
    got  = {hs_s, vs_s, de_s, vb_s, r_s, g_s, b_s};
    want = model_s(k_s);
    if (got !== want) begin
      if (blk_bad == 0) blk_msg = $sformatf("k=%0d pins got %h want %h", k_s, got, want);
      blk_bad++;
    end
    // addresses belong to raster position k itself
    h     = k_s % S_HT;
    v     = (k_s / S_HT) % S_VT;
    e_col = (h < S_HA) ? h / S_HSC : 0;
    if (col_s !== 4'(e_col) || (v < S_VA && row_s !== 3'(v / S_VSC))) begin
      if (blk_bad == 0)
        blk_msg = $sformatf("k=%0d addr got col %0d row %0d want col %0d row %0d",
                            k_s, col_s, row_s, e_col, v / S_VSC);
      blk_bad++;
    end
    blk_n++;
    if (blk_n == S_HT) flush_s();
  endtask

  task automatic clear_rec();
    hs_fall = -1; hs_rise = -1; vs_fall = -1; vs_rise = -1;
    prev_hs = 1'b1; prev_vs = 1'b1;
    vb_q.delete();
    blank_bad = 0; lit_bad = 0; de_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    k_d = rst_d ? 0 : k_d + 1;
    k_s = rst_s ? 0 : k_s + 1;
    @(negedge clk);
    if (chk_en) check_small();
    if (prev_hs && !hs_s && hs_fall < 0) hs_fall = k_s;
    if (!prev_hs && hs_s && hs_fall >= 0 && hs_rise < 0) hs_rise = k_s;
    if (prev_vs && !vs_s && vs_fall < 0) vs_fall = k_s;
    if (!prev_vs && vs_s && vs_fall >= 0 && vs_rise < 0) vs_rise = k_s;
    if (vb_s) vb_q.push_back(k_s);
    if (!de_s && {r_s, g_s, b_s} != 12'h000) blank_bad++;
    if (de_s && {r_s, g_s, b_s} != 12'hFFF) lit_bad++;
    if (de_s) de_cnt++;
    prev_hs = hs_s;
    prev_vs = vs_s;
  endtask

  typedef struct {
    int          k;
    logic        hs, vs, de;
    logic [6:0]  col;
    logic [5:0]  row;
    logic [11:0] rgb;
  } vec_t;
  vec_t vt[$];

  initial begin
    int rk;
    rst_d = 1'b1; rst_s = 1'b1; force_s = 1'b1; chk_en = 1'b0;
    k_d = 0; k_s = 0; blk_n = 0; blk_bad = 0; blk_msg = "";
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++)
        mem_s[r][c] = 12'($urandom);
    clear_rec();

    // default-timing vectors: k, hsync, vsync, de, col addr, row addr, rgb
    vt.push_back('{0,    1'b1, 1'b1, 1'b0, 7'd0,  6'd0, 12'h000});
    vt.push_back('{1,    1'b1, 1'b1, 1'b0, 7'd0,  6'd0, 12'h000});
    vt.push_back('{2,    1'b1, 1'b1, 1'b1, 7'd0,  6'd0, 12'h000});
    vt.push_back('{8,    1'b1, 1'b1, 1'b1, 7'd1,  6'd0, 12'h000});
    vt.push_back('{10,   1'b1, 1'b1, 1'b1, 7'd1,  6'd0, 12'h001});
    vt.push_back('{639,  1'b1, 1'b1, 1'b1, 7'd79, 6'd0, 12'h00F});
    vt.push_back('{640,  1'b1, 1'b1, 1'b1, 7'd0,  6'd0, 12'h00F});
    vt.push_back('{642,  1'b1, 1'b1, 1'b0, 7'd0,  6'd0, 12'h000});
    vt.push_back('{657,  1'b1, 1'b1, 1'b0, 7'd0,  6'd0, 12'h000});
    vt.push_back('{658,  1'b0, 1'b1, 1'b0, 7'd0,  6'd0, 12'h000});
    vt.push_back('{753,  1'b0, 1'b1, 1'b0, 7'd0,  6'd0, 12'h000});
    vt.push_back('{754,  1'b1, 1'b1, 1'b0, 7'd0,  6'd0, 12'h000});
    vt.push_back('{800,  1'b1, 1'b1, 1'b0, 7'd0,  6'd0, 12'h000});
    vt.push_back('{802,  1'b1, 1'b1, 1'b1, 7'd0,  6'd0, 12'h000});
    vt.push_back('{6399, 1'b1, 1'b1, 1'b0, 7'd0,  6'd0, 12'h000});
    vt.push_back('{6401, 1'b1, 1'b1, 1'b0, 7'd0,  6'd1, 12'h000});
    vt.push_back('{6408, 1'b1, 1'b1, 1'b1, 7'd1,  6'd1, 12'h040});
    vt.push_back('{6410, 1'b1, 1'b1, 1'b1, 7'd1,  6'd1, 12'h041});
    vt.push_back('{6417, 1'b1, 1'b1, 1'b1, 7'd2,  6'd1, 12'h041});
    vt.push_back('{6418, 1'b1, 1'b1, 1'b1, 7'd2,  6'd1, 12'h042});

    repeat (3) tick();
    rst_d = 1'b0;
    rst_s = 1'b0;
    clear_rec();
    chk_en = 1'b1;

    // default instance table, reduced instance runs alongside with 0xFFF data
    for (int i = 0; i < vt.size(); i++) begin
      while (k_d < vt[i].k) tick();
      chk($sformatf("vec@%0d {hs,vs,de,col,row,rgb}", vt[i].k),
          {hs_d, vs_d, de_d, col_d, row_d, r_d, g_d, b_d},
          {vt[i].hs, vt[i].vs, vt[i].de, vt[i].col, vt[i].row, vt[i].rgb});
    end

    // reduced instance: two full frames of output with data held at 0xFFF
    while (k_s < 2 * S_FRAME + 1) tick();
    flush_s();
    chk("hs_first_fall", hs_fall, S_HA + S_HFP + 2);
    chk("hs_low_width", hs_rise - hs_fall, S_HS);
    chk("vs_first_fall", vs_fall, (S_VA + S_VFP) * S_HT + 2);
    chk("vs_low_width", vs_rise - vs_fall, S_VS * S_HT);
    chk("vblank_count", vb_q.size(), 2);
    chk("vblank_first", (vb_q.size() > 0) ? vb_q[0] : -1, S_VA * S_HT + 2);
    chk("vblank_period", (vb_q.size() > 1) ? vb_q[1] - vb_q[0] : -1, S_FRAME);
    chk("blank_rgb_nonzero", blank_bad, 0);
    chk("active_rgb_not_fff", lit_bad, 0);
    chk("de_cycles", de_cnt, 2 * S_HA * S_VA);

    // random RAM image, then a reset at a random point mid-frame
    force_s = 1'b0;
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    clear_rec();
    rk = int'($urandom_range(6000, 1000));
    while (k_s < S_FRAME + rk) tick();
    flush_s();
    rst_s = 1'b1;
    tick();
    chk("midrst_outputs {hs,vs,de,vb,rgb,col,row}",
        {hs_s, vs_s, de_s, vb_s, r_s, g_s, b_s, col_s, row_s},
        {1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 4'd0, 3'd0});
    rst_s = 1'b0;
    clear_rec();
    while (k_s < S_FRAME + 1) tick();
    flush_s();
    chk("midrst_hs_first_fall", hs_fall, S_HA + S_HFP + 2);
    chk("midrst_vblank_count", vb_q.size(), 1);
    chk("midrst_vblank_first", (vb_q.size() > 0) ? vb_q[0] : -1, S_VA * S_HT + 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
